// File: rtl/doom_consts.sv
// Constants and types shared by the Doom drawing blocks: FSM encoding, patch
// header layout, screen geometry defaults and hps_params slot indices.
package doom_consts;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR      = 4'd1,
    ST_COLOFS   = 4'd2,
    ST_POST_TD  = 4'd3,
    ST_POST_LEN = 4'd4,
    ST_POST_PAD = 4'd5,
    ST_PIX_RD   = 4'd6,
    ST_PIX_WR   = 4'd7,
    ST_TAIL_PAD = 4'd8,
    ST_DONE     = 4'd9
  } state_t;

  localparam logic [7:0] POST_END = 8'hFF;

  // Header is four u16/s16 fields; byte offset of field k is 2*k.
  localparam logic [1:0] HDR_WIDTH   = 2'd0;
  localparam logic [1:0] HDR_HEIGHT  = 2'd1;
  localparam logic [1:0] HDR_LEFTOFS = 2'd2;
  localparam logic [1:0] HDR_TOPOFS  = 2'd3;
  localparam logic [31:0] COLOFS_BASE = 32'd8;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 200;

  localparam int PRM_X      = 1;
  localparam int PRM_Y      = 2;
  localparam int PRM_PATCH  = 3;
  localparam int PRM_SCREEN = 4;

  // Row offset for a 320-byte pitch as 256 + 64.
  function automatic logic [31:0] times_320(input logic [16:0] v);
    return ({15'd0, v} << 8) + ({15'd0, v} << 6);
  endfunction

endpackage

// File: rtl/le_field_reader.sv
// Assembles a little-endian 16/32-bit field from consecutive byte transfers;
// done strobes in the cycle of the last byte, with value already complete.
module le_field_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [2:0]  nbytes,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic [31:0] value,
  output logic        done
);

  logic [31:0] acc;
  logic [1:0]  idx;

  assign byte_idx = idx;
  assign done     = byte_en && ({1'b0, idx} == nbytes - 3'd1);

  // NOTE: value is fully assigned before the part-select overlay, so no latch is inferred.
  always_comb begin
    value = acc;
    value[8*idx +: 8] = byte_data;
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      acc <= '0;
      idx <= '0;
    end else if (byte_en) begin
      if (done) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= value;
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/patch_blitter.sv
// Walks a Doom patch (header, column offsets, posts) over the shared byte bus
// and writes every on-screen pixel into the 8-bit screen buffer.
module patch_blitter
  import doom_consts::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        processing,
  input  logic [31:0] hps_params [8],
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [7:0]  mem_readdata,
  output logic        mem_write,
  output logic [7:0]  mem_writedata,
  output logic [6:0]  debug_seg_export
);

  localparam logic [16:0] SCREEN_W17 = 17'(SCREEN_W);
  localparam logic [16:0] SCREEN_H17 = 17'(SCREEN_H);

  state_t             state;
  logic [31:0]        patch_base, screen_base, ptr, pix_addr;
  logic signed [16:0] x, y, ox, oy;
  logic [15:0]        width, height, leftofs, col;
  logic [1:0]         hdr_field;
  logic [7:0]         topdelta, len, pix_i, pix_data;

  logic               xfer, rd_en, rd_done, visible, last_pix;
  logic [1:0]         rd_idx;
  logic [31:0]        rd_value, row_ofs, wr_addr;
  logic signed [16:0] px, py;
  logic               unused_params;

  assign unused_params = ^{hps_params[0], hps_params[5], hps_params[6], hps_params[7],
                           hps_params[PRM_X][31:16], hps_params[PRM_Y][31:16]};

  assign xfer  = (mem_read || mem_write) && !mem_waitrequest;
  assign rd_en = xfer && (state == ST_HDR || state == ST_COLOFS);

  le_field_reader u_field (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state == ST_IDLE),
    .byte_en  (rd_en),
    .nbytes   ((state == ST_HDR) ? 3'd2 : 3'd4),
    .byte_data(mem_readdata),
    .byte_idx (rd_idx),
    .value    (rd_value),
    .done     (rd_done)
  );

  // Screen coordinate of the pixel currently being read.
  assign px = ox + $signed({1'b0, col});
  assign py = oy + $signed({9'd0, topdelta}) + $signed({9'd0, pix_i});

  assign visible = !px[16] && ($unsigned(px) < SCREEN_W17) &&
                   !py[16] && ($unsigned(py) < SCREEN_H17);
  assign row_ofs  = (SCREEN_W == 320) ? times_320(py) : ({15'd0, py} * 32'(SCREEN_W));
  assign wr_addr  = screen_base + row_ofs + {15'd0, px};
  assign last_pix = (pix_i + 8'd1 == len);

  assign debug_seg_export = {3'd0, state};

  // Bus strobes, address and data follow state directly so they hold through stalls.
  always_comb begin
    processing    = 1'b1;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      ST_IDLE: processing = start;
      ST_HDR: begin
        mem_read    = 1'b1;
        mem_address = patch_base + {29'd0, hdr_field, 1'b0} + {30'd0, rd_idx};
      end
      ST_COLOFS: begin
        mem_read    = 1'b1;
        mem_address = patch_base + COLOFS_BASE + {14'd0, col, 2'b00} + {30'd0, rd_idx};
      end
      ST_POST_TD, ST_POST_LEN, ST_PIX_RD: begin
        mem_read    = 1'b1;
        mem_address = ptr;
      end
      ST_PIX_WR: begin
        mem_write     = 1'b1;
        mem_address   = pix_addr;
        mem_writedata = pix_data;
      end
      ST_DONE: processing = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      patch_base  <= '0;
      screen_base <= '0;
      ptr         <= '0;
      pix_addr    <= '0;
      x           <= '0;
      y           <= '0;
      ox          <= '0;
      oy          <= '0;
      width       <= '0;
      height      <= '0;
      leftofs     <= '0;
      col         <= '0;
      hdr_field   <= '0;
      topdelta    <= '0;
      len         <= '0;
      pix_i       <= '0;
      pix_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x           <= {hps_params[PRM_X][15], hps_params[PRM_X][15:0]};
            y           <= {hps_params[PRM_Y][15], hps_params[PRM_Y][15:0]};
            patch_base  <= hps_params[PRM_PATCH];
            screen_base <= hps_params[PRM_SCREEN];
            hdr_field   <= '0;
            col         <= '0;
            state       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (rd_done) begin
            hdr_field <= hdr_field + 2'd1;
            case (hdr_field)
              HDR_WIDTH:   width   <= rd_value[15:0];
              HDR_HEIGHT:  height  <= rd_value[15:0];
              HDR_LEFTOFS: leftofs <= rd_value[15:0];
              default: begin
                ox <= x - {leftofs[15], leftofs};
                oy <= y - {rd_value[15], rd_value[15:0]};
                if (width == 16'd0 || height == 16'd0) state <= ST_DONE;
                else                                   state <= ST_COLOFS;
              end
            endcase
          end
        end
        ST_COLOFS: begin
          if (rd_done) begin
            ptr   <= patch_base + rd_value;
            state <= ST_POST_TD;
          end
        end
        ST_POST_TD: begin
          if (xfer) begin
            if (mem_readdata == POST_END) begin
              col <= col + 16'd1;
              if ({1'b0, col} + 17'd1 == {1'b0, width}) state <= ST_DONE;
              else                                      state <= ST_COLOFS;
            end else begin
              topdelta <= mem_readdata;
              ptr      <= ptr + 32'd1;
              state    <= ST_POST_LEN;
            end
          end
        end
        ST_POST_LEN: begin
          if (xfer) begin
            len   <= mem_readdata;
            ptr   <= ptr + 32'd1;
            state <= ST_POST_PAD;
          end
        end
        ST_POST_PAD: begin
          ptr   <= ptr + 32'd1;
          pix_i <= '0;
          if (len == 8'd0) state <= ST_TAIL_PAD;
          else             state <= ST_PIX_RD;
        end
        ST_PIX_RD: begin
          if (xfer) begin
            pix_data <= mem_readdata;
            ptr      <= ptr + 32'd1;
            if (visible) begin
              pix_addr <= wr_addr;
              state    <= ST_PIX_WR;
            end else if (last_pix) begin
              state <= ST_TAIL_PAD;
            end else begin
              pix_i <= pix_i + 8'd1;
            end
          end
        end
        ST_PIX_WR: begin
          if (xfer) begin
            if (last_pix) begin
              state <= ST_TAIL_PAD;
            end else begin
              pix_i <= pix_i + 8'd1;
              state <= ST_PIX_RD;
            end
          end
        end
        ST_TAIL_PAD: begin
          ptr   <= ptr + 32'd1;
          state <= ST_POST_TD;
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_blitter.sv
// Scoreboarded bench for patch_blitter: directed patches are placed in a byte
// memory model, expected screen writes are queued and checked by a bus monitor.
module tb_patch_blitter;
  import doom_consts::*;

  localparam logic [31:0] PB = 32'h0000_1000;
  localparam logic [31:0] SB = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        processing;
  logic [31:0] hps_params [8];
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [7:0]  mem_readdata = 8'h00;
  logic        mem_write;
  logic [7:0]  mem_writedata;
  logic [6:0]  debug_seg_export;

  always #5 clk = ~clk;

  patch_blitter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .processing      (processing),
    .hps_params      (hps_params),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .debug_seg_export(debug_seg_export)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] mem [logic [31:0]];
  wr_t        exp_q [$];
  int         total = 0;
  int         bad = 0;
  int         wr_count = 0;
  bit         rand_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: settles just after each rising edge.
  always @(posedge clk) begin
    #1;
    mem_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_readdata    = mem.exists(mem_address) ? mem[mem_address] : 8'h00;
  end

  // Monitor: pops the scoreboard on each completed write and checks stall stability.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (mem_read || mem_write)
        check("rw_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
      if (prev_stall) begin
        check("stall_addr", {32'd0, mem_address}, {32'd0, prev_addr});
        check("stall_strobes", {62'd0, mem_read, mem_write}, {62'd0, prev_rd, prev_wr});
        check("stall_wdata", {56'd0, mem_writedata}, {56'd0, prev_wdata});
      end
      if (mem_write && !mem_waitrequest) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_address, mem_writedata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {32'd0, mem_address}, {32'd0, e.addr});
          check("wr_data", {56'd0, mem_writedata}, {56'd0, e.data});
        end
      end
      prev_stall = (mem_read || mem_write) && mem_waitrequest;
      prev_addr  = mem_address;
      prev_wdata = mem_writedata;
      prev_rd    = mem_read;
      prev_wr    = mem_write;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic put8(input logic [31:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic put16(input logic [31:0] a, input logic [15:0] v);
    put8(a, v[7:0]);
    put8(a + 32'd1, v[15:8]);
  endtask

  task automatic put32(input logic [31:0] a, input logic [31:0] v);
    put16(a, v[15:0]);
    put16(a + 32'd2, v[31:16]);
  endtask

  task automatic put_header(input logic [15:0] w, input logic [15:0] h,
                            input logic [15:0] lo, input logic [15:0] to);
    put16(PB + 32'd0, w);
    put16(PB + 32'd2, h);
    put16(PB + 32'd4, lo);
    put16(PB + 32'd6, to);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // 1x1 patch: one post td=0 len=1 pixel 0x2A.
  task automatic build_one_px();
    mem.delete();
    put_header(16'd1, 16'd1, 16'd0, 16'd0);
    put32(PB + 32'd8, 32'd12);
    put8(PB + 32'd12, 8'h00);
    put8(PB + 32'd13, 8'h01);
    put8(PB + 32'd14, 8'h00);
    put8(PB + 32'd15, 8'h2A);
    put8(PB + 32'd16, 8'h00);
    put8(PB + 32'd17, POST_END);
  endtask

  // w x h patch, every column one full post, pixel = 0x10*col + row + 1.
  task automatic build_full(input int w, input int h);
    logic [31:0] c_at;
    mem.delete();
    put_header(16'(w), 16'(h), 16'd0, 16'd0);
    for (int c = 0; c < w; c++) begin
      c_at = 32'(8 + 4 * w + c * (h + 5));
      put32(PB + 32'd8 + 32'(4 * c), c_at);
      put8(PB + c_at, 8'h00);
      put8(PB + c_at + 32'd1, 8'(h));
      put8(PB + c_at + 32'd2, 8'h00);
      for (int r = 0; r < h; r++) put8(PB + c_at + 32'd3 + 32'(r), 8'(16 * c + r + 1));
      put8(PB + c_at + 32'(3 + h), 8'h00);
      put8(PB + c_at + 32'(4 + h), POST_END);
    end
  endtask

  task automatic run_patch(input string name, input int x, input int y,
                           input int exp_writes, output int cycles);
    hps_params[PRM_X]      = 32'(x);
    hps_params[PRM_Y]      = 32'(y);
    hps_params[PRM_PATCH]  = PB;
    hps_params[PRM_SCREEN] = SB;
    wr_count = 0;
    start = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (processing && cycles < 4000);
    check({name, "_done"}, {63'd0, processing}, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check({name, "_idle"}, {57'd0, debug_seg_export}, {57'd0, 3'd0, ST_IDLE});
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_nwrites"}, 64'(wr_count), 64'(exp_writes));
    exp_q.delete();
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 8; i++) hps_params[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_processing", {63'd0, processing}, 64'd0);
    check("rst_read", {63'd0, mem_read}, 64'd0);
    check("rst_write", {63'd0, mem_write}, 64'd0);
    check("rst_addr", {32'd0, mem_address}, 64'd0);
    check("rst_wdata", {56'd0, mem_writedata}, 64'd0);
    check("rst_debug", {57'd0, debug_seg_export}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single pixel at (10,5): 5*320+10 = 1610.
    build_one_px();
    expect_wr(SB + 32'd1610, 8'h2A);
    run_patch("one_px", 10, 5, 1, n);

    // Two columns, offsets (2,1) so origin is (10,5); col0 has a len-0 post
    // then td=3 len=2; col1 is empty. Pixels land at rows 8,9 of column 10.
    mem.delete();
    put_header(16'd2, 16'd8, 16'd2, 16'd1);
    put32(PB + 32'd8, 32'd16);
    put32(PB + 32'd12, 32'd27);
    put8(PB + 32'd16, 8'h00); put8(PB + 32'd17, 8'h00);
    put8(PB + 32'd18, 8'h00); put8(PB + 32'd19, 8'h00);
    put8(PB + 32'd20, 8'h03); put8(PB + 32'd21, 8'h02); put8(PB + 32'd22, 8'h00);
    put8(PB + 32'd23, 8'h55); put8(PB + 32'd24, 8'h66); put8(PB + 32'd25, 8'h00);
    put8(PB + 32'd26, POST_END);
    put8(PB + 32'd27, POST_END);
    expect_wr(SB + 32'd2570, 8'h55);
    expect_wr(SB + 32'd2890, 8'h66);
    run_patch("two_col", 12, 6, 2, n);

    // Left-edge clip: x=-1, column 0 is off screen.
    build_full(3, 2);
    expect_wr(SB + 32'd1600, 8'h11);
    expect_wr(SB + 32'd1920, 8'h12);
    expect_wr(SB + 32'd1601, 8'h21);
    expect_wr(SB + 32'd1921, 8'h22);
    run_patch("clip_left", -1, 5, 4, n);

    // Same patch at y=199: row 200 is clipped.
    expect_wr(SB + 32'd63680, 8'h11);
    expect_wr(SB + 32'd63681, 8'h21);
    run_patch("clip_bottom", -1, 199, 2, n);

    // Right-edge clip: x=318, column 2 lands on px=320.
    expect_wr(SB + 32'd1918, 8'h01);
    expect_wr(SB + 32'd2238, 8'h02);
    expect_wr(SB + 32'd1919, 8'h11);
    expect_wr(SB + 32'd2239, 8'h12);
    run_patch("clip_right", 318, 5, 4, n);

    // Zero width: header only, DONE within 9 cycles.
    mem.delete();
    put_header(16'd0, 16'd5, 16'd0, 16'd0);
    run_patch("width0", 10, 5, 0, n);
    check("width0_latency", {63'd0, n <= 9}, 64'd1);

    // Random stalls on the single-pixel case.
    build_one_px();
    rand_wait = 1'b1;
    expect_wr(SB + 32'd1610, 8'h2A);
    run_patch("stall_one_px", 10, 5, 1, n);
    rand_wait = 1'b0;
    @(negedge clk);

    // Reset during PIX_RD: back to IDLE, no strobes, no write afterwards.
    build_one_px();
    hps_params[PRM_X] = 32'd10;
    hps_params[PRM_Y] = 32'd5;
    wr_count = 0;
    start = 1'b1;
    n = 0;
    while (debug_seg_export != {3'd0, ST_PIX_RD} && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", {63'd0, n < 200}, 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_state", {57'd0, debug_seg_export}, {57'd0, 3'd0, ST_IDLE});
    check("rst_mid_read", {63'd0, mem_read}, 64'd0);
    check("rst_mid_write", {63'd0, mem_write}, 64'd0);
    check("rst_mid_processing", {63'd0, processing}, {63'd0, start});
    start = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_nwrites", 64'(wr_count), 64'd0);
    check("rst_mid_quiet", {62'd0, mem_read, mem_write}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
